// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and mem_system side of the shared-memory arbiter.
// The arbiter uses the slave view; the environment driving requests and memory responses uses master.
interface mem_port_arbiter_if;
  logic [15:0] i_addr;
  logic        i_read;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        i_cache_hit;

  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic        d_cache_hit;

  logic [15:0] ms_addr;
  logic [15:0] ms_data_in;
  logic        ms_read;
  logic        ms_write;
  logic [15:0] ms_data_out;
  logic        ms_done;
  logic        ms_stall;
  logic        ms_cache_hit;

  logic        err;

  modport slave (
    input  i_addr, i_read, d_addr, d_data_in, d_read, d_write,
           ms_data_out, ms_done, ms_stall, ms_cache_hit,
    output i_data_out, i_done, i_stall, i_cache_hit,
           d_data_out, d_done, d_stall, d_cache_hit,
           ms_addr, ms_data_in, ms_read, ms_write, err
  );

  modport master (
    output i_addr, i_read, d_addr, d_data_in, d_read, d_write,
           ms_data_out, ms_done, ms_stall, ms_cache_hit,
    input  i_data_out, i_done, i_stall, i_cache_hit,
           d_data_out, d_done, d_stall, d_cache_hit,
           ms_addr, ms_data_in, ms_read, ms_write, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one mem_system between the fetch (I) and data (D) ports,
// with a watchdog that aborts hung transactions and a sticky error flag.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ABORT} state_t;

  state_t          state;
  state_t          state_next;
  logic            owner_d;
  logic            last_d;
  logic            write_q;
  logic            err_q;
  logic [15:0]     addr_q;
  logic [15:0]     data_q;
  logic [TO_W-1:0] wdog;

  logic            d_valid;
  logic            d_conflict;
  logic            grant;
  logic            grant_d;
  logic            resp_ok;
  logic            done_any;
  logic            spurious;
  logic            i_done_w;
  logic            d_done_w;
  logic [15:0]     resp_data;
  logic            resp_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b1;
      last_d  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wdog    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner_d <= grant_d;
        addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
        data_q  <= grant_d ? bus.d_data_in : '0;
        write_q <= grant_d & bus.d_write;
      end
      if (state == ISSUE) begin
        last_d <= owner_d;
        wdog   <= '0;
      end else if (state == WAIT) begin
        wdog <= wdog + TO_W'(1);
      end
      if (d_conflict || spurious || state == ABORT) begin
        err_q <= 1'b1;
      end
    end
  end

  // A D request with both read and write set is never a candidate for the grant.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    d_valid    = bus.d_read ^ bus.d_write;
    d_conflict = bus.d_read & bus.d_write;

    case (state)
      IDLE: begin
        if (bus.i_read || d_valid) begin
          grant      = 1'b1;
          grant_d    = (bus.i_read && d_valid) ? ~last_d : d_valid;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (bus.ms_done) begin
          state_next = IDLE;
        end else if (wdog == TO_W'(TIMEOUT - 1)) begin
          state_next = ABORT;
        end
      end
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase

    resp_ok   = (state == WAIT) && bus.ms_done;
    done_any  = resp_ok || (state == ABORT);
    resp_data = resp_ok ? bus.ms_data_out : '0;
    resp_hit  = resp_ok & bus.ms_cache_hit;
    spurious  = bus.ms_done && (state == IDLE || state == ISSUE);
    i_done_w  = done_any & ~owner_d;
    d_done_w  = done_any & owner_d;

    bus.ms_read     = (state == ISSUE) & ~write_q;
    bus.ms_write    = (state == ISSUE) & write_q;
    bus.ms_addr     = addr_q;
    bus.ms_data_in  = data_q;
    bus.i_done      = i_done_w;
    bus.d_done      = d_done_w;
    bus.i_data_out  = i_done_w ? resp_data : '0;
    bus.d_data_out  = d_done_w ? resp_data : '0;
    bus.i_cache_hit = i_done_w & resp_hit;
    bus.d_cache_hit = d_done_w & resp_hit;
    bus.i_stall     = bus.i_read & ~i_done_w;
    bus.d_stall     = (bus.d_read | bus.d_write) & ~d_done_w;
    bus.err         = err_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a timed mem_system responder plus a
// transaction-level round-robin model of which port should own each access.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(64), .TO_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_lat = 2;
  bit          mem_hang = 1'b0;
  bit          fixed_en = 1'b0;
  logic [15:0] fixed_data = 16'h0000;
  bit          fixed_hit = 1'b0;
  bit          inject_spurious = 1'b0;
  int          resp_cnt = 0;
  bit          resp_active = 1'b0;
  logic [15:0] resp_data = 16'h0000;
  bit          resp_hit = 1'b0;

  // Memory-side responder: answers each issue pulse mem_lat cycles later and drives garbage otherwise.
  initial begin
    bus.ms_done = 1'b0; bus.ms_data_out = '0; bus.ms_cache_hit = 1'b0; bus.ms_stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      resp_active = 1'b0;
      if (inject_spurious) begin
        resp_active = 1'b1; resp_data = 16'($urandom); resp_hit = 1'b1; inject_spurious = 1'b0;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_active = 1'b1;
          resp_data = fixed_en ? fixed_data : 16'($urandom);
          resp_hit = fixed_en ? fixed_hit : 1'($urandom);
        end
      end
      bus.ms_done      = resp_active;
      bus.ms_data_out  = resp_active ? resp_data : 16'($urandom);
      bus.ms_cache_hit = resp_active ? resp_hit : 1'($urandom);
      bus.ms_stall     = (resp_cnt > 0);
      @(negedge clk);
      if (rst) resp_cnt = 0;
      else if ((bus.ms_read || bus.ms_write) && !mem_hang) resp_cnt = mem_lat;
    end
  end

  task automatic to_next;
    @(posedge clk); #1;
  endtask

  task automatic clear_requests;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_data_in = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1; clear_requests();
    mem_hang = 1'b0; fixed_en = 1'b0; mem_lat = 2;
    repeat (2) to_next();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear_requests();
    to_next();
    @(negedge clk);
    n_checks++; if ({bus.ms_read, bus.ms_write, bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit, bus.err, bus.i_stall, bus.d_stall} !== 9'b0) begin n_errors++; $display("[TB] FAIL reset_flags: got %b expected 0", {bus.ms_read, bus.ms_write, bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit, bus.err, bus.i_stall, bus.d_stall}); end
    n_checks++; if ({bus.ms_addr, bus.ms_data_in, bus.i_data_out, bus.d_data_out} !== 64'h0) begin n_errors++; $display("[TB] FAIL reset_buses: got %h expected 0", {bus.ms_addr, bus.ms_data_in, bus.i_data_out, bus.d_data_out}); end
    to_next();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.ms_read, bus.ms_write, bus.err, bus.i_done, bus.d_done} !== 5'b0) begin n_errors++; $display("[TB] FAIL idle_after_reset: got %b expected 0", {bus.ms_read, bus.ms_write, bus.err, bus.i_done, bus.d_done}); end
    to_next();
  endtask

  task automatic test_single_i;
    do_reset();
    fixed_en = 1'b1; fixed_data = 16'hBEEF; fixed_hit = 1'b1; mem_lat = 2;
    bus.i_addr = 16'h0010; bus.i_read = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.ms_read !== (k == 1)) begin n_errors++; $display("[TB] FAIL single_ms_read c%0d: got %b expected %b", k, bus.ms_read, (k == 1)); end
      n_checks++; if (bus.i_done !== (k == 3)) begin n_errors++; $display("[TB] FAIL single_i_done c%0d: got %b expected %b", k, bus.i_done, (k == 3)); end
      n_checks++; if (bus.i_stall !== (k != 3)) begin n_errors++; $display("[TB] FAIL single_i_stall c%0d: got %b expected %b", k, bus.i_stall, (k != 3)); end
      if (k == 1) begin
        n_checks++; if (bus.ms_addr !== 16'h0010) begin n_errors++; $display("[TB] FAIL single_ms_addr: got %h expected 0010", bus.ms_addr); end
      end
      if (k == 3) begin
        n_checks++; if (bus.i_data_out !== 16'hBEEF) begin n_errors++; $display("[TB] FAIL single_i_data: got %h expected beef", bus.i_data_out); end
        n_checks++; if (bus.i_cache_hit !== 1'b1) begin n_errors++; $display("[TB] FAIL single_i_hit: got %b expected 1", bus.i_cache_hit); end
        n_checks++; if ({bus.d_done, bus.d_cache_hit, bus.d_data_out} !== 18'h0) begin n_errors++; $display("[TB] FAIL single_d_quiet: got %h expected 0", {bus.d_done, bus.d_cache_hit, bus.d_data_out}); end
      end
      to_next();
    end
    bus.i_read = 1'b0; fixed_en = 1'b0;
  endtask

  task automatic test_contention;
    int          n_iss = 0;
    bit          seen_i = 1'b0, seen_d = 1'b0, exp_id, exp_dd;
    logic [15:0] iss_addr [2];
    logic [15:0] iss_data [2];
    bit          iss_wr [2];
    do_reset();
    bus.i_addr = 16'h0020; bus.i_read = 1'b1;
    bus.d_addr = 16'h0100; bus.d_data_in = 16'h1234; bus.d_write = 1'b1;
    for (int k = 0; k < 40 && !seen_d; k++) begin
      @(negedge clk);
      if (bus.ms_read || bus.ms_write) begin
        if (n_iss < 2) begin iss_addr[n_iss] = bus.ms_addr; iss_data[n_iss] = bus.ms_data_in; iss_wr[n_iss] = bus.ms_write; end
        n_iss++;
      end
      exp_id = resp_active && !seen_i;
      exp_dd = resp_active && seen_i;
      n_checks++; if ({bus.i_done, bus.d_done, bus.d_stall} !== {exp_id, exp_dd, !exp_dd}) begin n_errors++; $display("[TB] FAIL contend_done_stall c%0d: got %b expected %b", k, {bus.i_done, bus.d_done, bus.d_stall}, {exp_id, exp_dd, !exp_dd}); end
      if (exp_id) begin
        n_checks++; if (bus.i_data_out !== resp_data) begin n_errors++; $display("[TB] FAIL contend_i_data: got %h expected %h", bus.i_data_out, resp_data); end
        seen_i = 1'b1;
      end
      if (exp_dd) begin
        n_checks++; if (bus.d_data_out !== resp_data) begin n_errors++; $display("[TB] FAIL contend_d_data: got %h expected %h", bus.d_data_out, resp_data); end
        seen_d = 1'b1;
      end
      to_next();
      if (seen_i) bus.i_read = 1'b0;
    end
    clear_requests();
    n_checks++; if (seen_d !== 1'b1) begin n_errors++; $display("[TB] FAIL contend_d_completes: got %b expected 1", seen_d); end
    n_checks++; if (n_iss !== 2) begin n_errors++; $display("[TB] FAIL contend_issue_count: got %0d expected 2", n_iss); end
    if (n_iss >= 2) begin
      n_checks++; if ({iss_wr[0], iss_addr[0]} !== {1'b0, 16'h0020}) begin n_errors++; $display("[TB] FAIL contend_first_issue: got wr=%b addr=%h expected wr=0 addr=0020", iss_wr[0], iss_addr[0]); end
      n_checks++; if ({iss_wr[1], iss_addr[1], iss_data[1]} !== {1'b1, 16'h0100, 16'h1234}) begin n_errors++; $display("[TB] FAIL contend_second_issue: got wr=%b addr=%h data=%h expected 1/0100/1234", iss_wr[1], iss_addr[1], iss_data[1]); end
    end
  endtask

  // Model: each grant goes to the only valid port, or on a tie to the port that was not served last.
  task automatic test_traffic(input bit continuous, input int n_txn);
    bit          i_pend = 1'b0, d_pend = 1'b0, d_wr = 1'b0, pi = 1'b0, pd = 1'b0;
    bit          last_d = 1'b1, owner_d = 1'b0, busy = 1'b0, exp_dn, exp_id, exp_dd;
    logic [15:0] i_a = '0, d_a = '0, d_wd = '0;
    bit          grants [$];
    int          done_cnt = 0, cyc = 0;
    do_reset();
    while (done_cnt < n_txn && cyc < 3000) begin
      if (!i_pend && (continuous || $urandom_range(0, 3) == 0)) begin
        i_pend = 1'b1; i_a = 16'($urandom_range(0, 32767));
      end
      if (!d_pend && (continuous || $urandom_range(0, 3) == 0)) begin
        d_pend = 1'b1; d_a = 16'h8000 | 16'($urandom_range(0, 32767)); d_wr = 1'($urandom); d_wd = 16'($urandom);
      end
      bus.i_read = i_pend; bus.i_addr = i_a;
      bus.d_read = d_pend && !d_wr; bus.d_write = d_pend && d_wr; bus.d_addr = d_a; bus.d_data_in = d_wd;
      mem_lat = $urandom_range(1, 4);
      @(negedge clk);
      if (bus.ms_read || bus.ms_write) begin
        exp_dn = (pi && pd) ? !last_d : pd;
        n_checks++; if ({bus.ms_addr, bus.ms_write, bus.ms_read} !== {(exp_dn ? d_a : i_a), (exp_dn && d_wr), !(exp_dn && d_wr)}) begin n_errors++; $display("[TB] FAIL traffic_issue c%0d: got addr=%h wr=%b rd=%b expected owner_d=%b addr=%h", cyc, bus.ms_addr, bus.ms_write, bus.ms_read, exp_dn, (exp_dn ? d_a : i_a)); end
        if (exp_dn && d_wr) begin
          n_checks++; if (bus.ms_data_in !== d_wd) begin n_errors++; $display("[TB] FAIL traffic_store_data: got %h expected %h", bus.ms_data_in, d_wd); end
        end
        last_d = exp_dn; owner_d = exp_dn; busy = 1'b1; grants.push_back(exp_dn);
      end
      exp_id = busy && resp_active && !owner_d;
      exp_dd = busy && resp_active && owner_d;
      n_checks++; if ({bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit, bus.i_stall, bus.d_stall} !== {exp_id, exp_dd, exp_id && resp_hit, exp_dd && resp_hit, i_pend && !exp_id, d_pend && !exp_dd}) begin n_errors++; $display("[TB] FAIL traffic_flags c%0d: got %b expected %b", cyc, {bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit, bus.i_stall, bus.d_stall}, {exp_id, exp_dd, exp_id && resp_hit, exp_dd && resp_hit, i_pend && !exp_id, d_pend && !exp_dd}); end
      n_checks++; if ({bus.i_data_out, bus.d_data_out} !== {(exp_id ? resp_data : 16'h0), (exp_dd ? resp_data : 16'h0)}) begin n_errors++; $display("[TB] FAIL traffic_data c%0d: got %h expected %h", cyc, {bus.i_data_out, bus.d_data_out}, {(exp_id ? resp_data : 16'h0), (exp_dd ? resp_data : 16'h0)}); end
      pi = i_pend; pd = d_pend;
      if (exp_id) begin i_pend = 1'b0; busy = 1'b0; done_cnt++; end
      if (exp_dd) begin d_pend = 1'b0; busy = 1'b0; done_cnt++; end
      cyc++;
      to_next();
    end
    clear_requests();
    n_checks++; if (done_cnt !== n_txn) begin n_errors++; $display("[TB] FAIL traffic_completed: got %0d expected %0d", done_cnt, n_txn); end
    if (continuous) begin
      foreach (grants[k]) begin
        n_checks++; if (grants[k] !== (k % 2 == 1)) begin n_errors++; $display("[TB] FAIL alternate_grant %0d: got owner_d=%b expected %b", k, grants[k], (k % 2 == 1)); end
      end
    end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("[TB] FAIL traffic_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_timeout;
    do_reset();
    mem_hang = 1'b1;
    bus.d_addr = 16'h0300; bus.d_read = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (bus.ms_read !== 1'b1) begin n_errors++; $display("[TB] FAIL timeout_issue: got %b expected 1", bus.ms_read); end
      end
      n_checks++; if (bus.d_done !== (k == 66)) begin n_errors++; $display("[TB] FAIL timeout_d_done c%0d: got %b expected %b", k, bus.d_done, (k == 66)); end
      if (k == 66) begin
        n_checks++; if ({bus.d_data_out, bus.d_cache_hit, bus.i_done} !== 18'h0) begin n_errors++; $display("[TB] FAIL timeout_abort_outputs: got %h expected 0", {bus.d_data_out, bus.d_cache_hit, bus.i_done}); end
      end
      n_checks++; if (bus.err !== (k >= 67)) begin n_errors++; $display("[TB] FAIL timeout_err c%0d: got %b expected %b", k, bus.err, (k >= 67)); end
      to_next();
      if (k == 66) bus.d_read = 1'b0;
    end
    do_reset();
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("[TB] FAIL err_cleared_by_rst: got %b expected 0", bus.err); end
    to_next();
  endtask

  task automatic test_conflict;
    do_reset();
    mem_lat = 2;
    bus.d_addr = 16'h0200; bus.d_read = 1'b1; bus.d_write = 1'b1;
    bus.i_addr = 16'h0030; bus.i_read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if ({bus.ms_write, bus.ms_read} !== {1'b0, (k == 1)}) begin n_errors++; $display("[TB] FAIL conflict_issue c%0d: got wr=%b rd=%b expected wr=0 rd=%b", k, bus.ms_write, bus.ms_read, (k == 1)); end
      if (k == 1) begin
        n_checks++; if (bus.ms_addr !== 16'h0030) begin n_errors++; $display("[TB] FAIL conflict_i_addr: got %h expected 0030", bus.ms_addr); end
      end
      n_checks++; if ({bus.i_done, bus.d_done, bus.d_stall} !== {(k == 3), 1'b0, 1'b1}) begin n_errors++; $display("[TB] FAIL conflict_ports c%0d: got %b expected %b", k, {bus.i_done, bus.d_done, bus.d_stall}, {(k == 3), 1'b0, 1'b1}); end
      n_checks++; if (bus.err !== (k >= 1)) begin n_errors++; $display("[TB] FAIL conflict_err c%0d: got %b expected %b", k, bus.err, (k >= 1)); end
      to_next();
      if (k == 3) bus.i_read = 1'b0;
    end
    clear_requests();
  endtask

  task automatic test_spurious;
    do_reset();
    @(negedge clk);
    inject_spurious = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_next();
      @(negedge clk);
      n_checks++; if ({bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit} !== 4'b0) begin n_errors++; $display("[TB] FAIL spurious_no_done c%0d: got %b expected 0", k, {bus.i_done, bus.d_done, bus.i_cache_hit, bus.d_cache_hit}); end
      n_checks++; if (bus.err !== (k >= 1)) begin n_errors++; $display("[TB] FAIL spurious_err c%0d: got %b expected %b", k, bus.err, (k >= 1)); end
    end
    to_next();
  endtask

  task automatic test_rst_mid;
    do_reset();
    mem_hang = 1'b1;
    bus.d_addr = 16'h0440; bus.d_data_in = 16'h5A5A; bus.d_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        n_checks++; if ({bus.ms_addr, bus.ms_data_in, bus.ms_write} !== {16'h0440, 16'h5A5A, (k == 1)}) begin n_errors++; $display("[TB] FAIL rstmid_latched c%0d: got %h/%h wr=%b expected 0440/5a5a wr=%b", k, bus.ms_addr, bus.ms_data_in, bus.ms_write, (k == 1)); end
      end
      to_next();
    end
    rst = 1'b1; bus.d_write = 1'b0;
    to_next();
    rst = 1'b0; mem_hang = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if ({bus.ms_addr, bus.ms_data_in, bus.ms_read, bus.ms_write, bus.d_done, bus.err, bus.d_stall} !== 37'h0) begin n_errors++; $display("[TB] FAIL rstmid_outputs c%0d: got %h expected 0", k, {bus.ms_addr, bus.ms_data_in, bus.ms_read, bus.ms_write, bus.d_done, bus.err, bus.d_stall}); end
      to_next();
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    clear_requests();
    test_reset();
    test_single_i();
    test_contention();
    test_traffic(1'b1, 6);
    test_traffic(1'b0, 30);
    test_timeout();
    test_conflict();
    test_spurious();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
